aes_dec_core: RTL and testbench

//  Iterative AES-128 decryption core: the inverse of the encryption datapath.

---
 rtl/aes_pkg.sv | 83 ++++++++
 rtl/aes_dec_core_dec_round.sv | 33 +++
 rtl/aes_dec_core.sv | 142 ++++++++++++++
 tb/tb_aes_dec_core.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: forward/inverse S-boxes, Rcon, GF(2^8) helpers and state typedefs.
// State byte i lives in bits [127-8*i -: 8]; column c holds bytes 4c..4c+3.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  word_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXPAND,
    ST_DEC,
    ST_DONE
  } dec_state_e;

  localparam int STATE_MSB = 127;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  localparam logic [79:0] RCON = 80'h01020408102040801b36;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_SBOX[2047 - 8*int'(x) -: 8];
  endfunction

  // Rcon[1..10]; index 0 and >10 never occur during expansion.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    if (i == 4'd0 || i > 4'd10) return 8'h00;
    return RCON[87 - 8*int'(i) -: 8];
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic word_t inv_mix_col(input word_t w);
    logic [7:0] a0, a1, a2, a3;
    a0 = w[31:24];
    a1 = w[23:16];
    a2 = w[15:8];
    a3 = w[7:0];
    return {gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09),
            gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d),
            gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b),
            gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e)};
  endfunction

endpackage

// File: rtl/aes_dec_core_dec_round.sv
// One combinational inverse AES round; the final round (last=1) skips InvMixColumns.
module dec_round
  import aes_pkg::*;
(
  input  state_t state,
  input  state_t key,
  input  logic   last,
  output state_t state_out
);

  state_t shifted;
  state_t added;
  state_t mixed;

  // Row r of column c is taken from column (c - r) mod 4 before substitution.
  always_comb begin
    shifted = '0;
    added   = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        shifted[STATE_MSB - 8*(4*c + r) -: 8] =
          inv_sbox(state[STATE_MSB - 8*(4*((c - r + 4) % 4) + r) -: 8]);
      end
    end
    added = shifted ^ key;
    for (int c = 0; c < 4; c++) begin
      mixed[STATE_MSB - 32*c -: 32] = inv_mix_col(added[STATE_MSB - 32*c -: 32]);
    end
    state_out = last ? added : mixed;
  end

endmodule

// File: rtl/aes_dec_core.sv
// Iterative AES-128 decryption core: expands the key into an 11-entry table,
// then runs one inverse round per clock using round keys rk10 down to rk0.
module aes_dec_core
  import aes_pkg::*;
#(
  parameter int NR    = 10,
  parameter int KEY_W = 128,
  parameter int BLK_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic [BLK_W-1:0] ct_in,
  input  logic             ct_valid,
  output logic             ct_ready,
  output logic [BLK_W-1:0] pt_out,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic             keys_rdy
);

  dec_state_e state_q, state_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic       keys_rdy_q, keys_rdy_d;
  logic       pt_valid_q, pt_valid_d;
  state_t     pt_out_q, pt_out_d;
  state_t     st_q, st_d;
  state_t     rk_q [0:NR];
  state_t     rk_d [0:NR];
  state_t     round_out;

  function automatic state_t next_round_key(input state_t prev, input logic [7:0] rc);
    word_t w3, tmp, n0, n1, n2, n3;
    w3  = prev[31:0];
    tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    n0  = prev[127:96] ^ tmp;
    n1  = prev[95:64] ^ n0;
    n2  = prev[63:32] ^ n1;
    n3  = prev[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  dec_round u_round (
    .state    (st_q),
    .key      (rk_q[rcnt_q]),
    .last     (rcnt_q == 4'd0),
    .state_out(round_out)
  );

  always_comb begin
    state_d    = state_q;
    rcnt_d     = rcnt_q;
    keys_rdy_d = keys_rdy_q;
    pt_valid_d = pt_valid_q;
    pt_out_d   = pt_out_q;
    st_d       = st_q;
    rk_d       = rk_q;
    key_ready  = 1'b0;
    ct_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        key_ready = 1'b1;
        ct_ready  = keys_rdy_q & ~pt_valid_q & ~key_valid;
        if (key_valid) begin
          rk_d[0]    = key_in;
          rcnt_d     = 4'd1;
          keys_rdy_d = 1'b0;
          state_d    = ST_EXPAND;
        end else if (ct_valid && ct_ready) begin
          st_d    = ct_in ^ rk_q[NR];
          rcnt_d  = 4'(NR - 1);
          state_d = ST_DEC;
        end
      end
      ST_EXPAND: begin
        rk_d[rcnt_q] = next_round_key(rk_q[rcnt_q - 4'd1], rcon(rcnt_q));
        if (rcnt_q == 4'(NR)) begin
          keys_rdy_d = 1'b1;
          rcnt_d     = 4'd0;
          state_d    = ST_IDLE;
        end else begin
          rcnt_d = rcnt_q + 4'd1;
        end
      end
      ST_DEC: begin
        st_d = round_out;
        if (rcnt_q == 4'd0) begin
          pt_out_d   = round_out;
          pt_valid_d = 1'b1;
          state_d    = ST_DONE;
        end else begin
          rcnt_d = rcnt_q - 4'd1;
        end
      end
      ST_DONE: begin
        // Releasing the result and taking the next block can share one edge.
        ct_ready = keys_rdy_q & pt_ready;
        if (pt_ready) begin
          pt_valid_d = 1'b0;
          if (ct_valid && ct_ready) begin
            st_d    = ct_in ^ rk_q[NR];
            rcnt_d  = 4'(NR - 1);
            state_d = ST_DEC;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rcnt_q     <= 4'd0;
      keys_rdy_q <= 1'b0;
      pt_valid_q <= 1'b0;
      pt_out_q   <= '0;
      st_q       <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      keys_rdy_q <= keys_rdy_d;
      pt_valid_q <= pt_valid_d;
      pt_out_q   <= pt_out_d;
      st_q       <= st_d;
    end
  end

  // The table needs no reset: keys_rdy gates every use of it.
  always_ff @(posedge clk) begin
    rk_q <= rk_d;
  end

  assign pt_out   = pt_out_q;
  assign pt_valid = pt_valid_q;
  assign keys_rdy = keys_rdy_q;

endmodule

// File: tb/tb_aes_dec_core.sv
// Directed bench for aes_dec_core: FIPS-197 vectors, handshakes, reset abort and
// a round-trip check against a forward-cipher reference model.
module tb_aes_dec_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] ct_in;
  logic         ct_valid;
  logic         ct_ready;
  logic [127:0] pt_out;
  logic         pt_valid;
  logic         pt_ready;
  logic         keys_rdy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] RK10_2 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  always #5 clk = ~clk;

  aes_dec_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .key_in   (key_in),
    .key_valid(key_valid),
    .key_ready(key_ready),
    .ct_in    (ct_in),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .pt_out   (pt_out),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .keys_rdy (keys_rdy)
  );

  // Forward-cipher reference model; the S-box is derived from GF inverse + affine map.
  logic [7:0]   m_sbox [256];
  logic [127:0] m_rk [0:10];

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] m_rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic init_model();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      m_sbox[x] = inv ^ m_rotl(inv, 1) ^ m_rotl(inv, 2) ^ m_rotl(inv, 3) ^ m_rotl(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [7:0]  rc;
    logic [31:0] w3, t, n0, n1, n2, n3;
    rc = 8'h01;
    m_rk[0] = k;
    for (int r = 1; r <= 10; r++) begin
      w3 = m_rk[r-1][31:0];
      t  = {m_sbox[w3[23:16]], m_sbox[w3[15:8]], m_sbox[w3[7:0]], m_sbox[w3[31:24]]} ^ {rc, 24'h0};
      n0 = m_rk[r-1][127:96] ^ t;
      n1 = m_rk[r-1][95:64] ^ n0;
      n2 = m_rk[r-1][63:32] ^ n1;
      n3 = w3 ^ n2;
      m_rk[r] = {n0, n1, n2, n3};
      rc = m_mul(rc, 8'h02);
    end
  endtask

  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [127:0] s, t;
    logic [7:0]   a0, a1, a2, a3;
    s = pt ^ m_rk[0];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) s[127-8*i -: 8] = m_sbox[s[127-8*i -: 8]];
      t = s;
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++)
          t[127-8*(4*c+w) -: 8] = s[127-8*(4*((c+w)%4)+w) -: 8];
      s = t;
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[127-32*c -: 8];  a1 = s[119-32*c -: 8];
          a2 = s[111-32*c -: 8];  a3 = s[103-32*c -: 8];
          s[127-32*c -: 32] = {m_mul(a0, 8'h02) ^ m_mul(a1, 8'h03) ^ a2 ^ a3,
                               a0 ^ m_mul(a1, 8'h02) ^ m_mul(a2, 8'h03) ^ a3,
                               a0 ^ a1 ^ m_mul(a2, 8'h02) ^ m_mul(a3, 8'h03),
                               m_mul(a0, 8'h03) ^ a1 ^ a2 ^ m_mul(a3, 8'h02)};
        end
      end
      s = s ^ m_rk[r];
    end
    return s;
  endfunction

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0; key_valid = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0;
    key_in = '0; ct_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send_key(input logic [127:0] k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      key_in = k; key_valid = 1'b1;
      #1 ok = key_ready;
    end
    @(posedge clk);
    #1 key_valid = 1'b0;
  endtask

  task automatic send_ct(input logic [127:0] c, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ct_in = c; ct_valid = 1'b1;
      #1 ok = ct_ready;
    end
    @(posedge clk);
    #1 ct_valid = 1'b0;
  endtask

  task automatic wait_keys(output bit ok, output int edges);
    ok = 1'b0; edges = 0;
    while (!ok && edges < 40) begin
      @(posedge clk);
      #1 edges++;
      ok = keys_rdy;
    end
  endtask

  task automatic wait_pt(output bit ok, output int edges);
    ok = 1'b0; edges = 0;
    while (!ok && edges < 40) begin
      @(posedge clk);
      #1 edges++;
      ok = pt_valid;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    pt_ready = 1'b1;
    @(posedge clk);
    #1 pt_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_dut();
    #1;
    checks++; if (keys_rdy !== 1'b0) begin errors++; $display("[TB] FAIL reset_keys_rdy: got %b expected 0", keys_rdy); end
    checks++; if (pt_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_pt_valid: got %b expected 0", pt_valid); end
    checks++; if (pt_out !== 128'h0) begin errors++; $display("[TB] FAIL reset_pt_out: got %h expected 0", pt_out); end
    checks++; if (key_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_key_ready: got %b expected 1", key_ready); end
    checks++; if (ct_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ct_ready: got %b expected 0", ct_ready); end
    checks++; if (dut.rcnt_q !== 4'd0) begin errors++; $display("[TB] FAIL reset_rcnt: got %0d expected 0", dut.rcnt_q); end
  endtask

  task automatic test_fips_c1();
    bit ok;
    int edges;
    send_key(K1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL c1_key_accept: got no handshake expected handshake"); end
    wait_keys(ok, edges);
    checks++; if (!ok || edges != 10) begin errors++; $display("[TB] FAIL c1_expand_cycles: got %0d expected 10", edges); end
    send_ct(CT1, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL c1_ct_accept: got no handshake expected handshake"); end
    wait_pt(ok, edges);
    checks++; if (!ok || edges != 10) begin errors++; $display("[TB] FAIL c1_latency: got %0d edges expected 10", edges); end
    checks++; if (pt_out !== PT1) begin errors++; $display("[TB] FAIL c1_plaintext: got %h expected %h", pt_out, PT1); end
    consume();
    checks++; if (pt_valid !== 1'b0) begin errors++; $display("[TB] FAIL c1_pt_release: got %b expected 0", pt_valid); end
  endtask

  task automatic test_fips_b();
    bit ok;
    int edges;
    send_key(K2, ok);
    wait_keys(ok, edges);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b_keys_rdy: got timeout expected keys_rdy"); end
    checks++; if (dut.rk_q[10] !== RK10_2) begin errors++; $display("[TB] FAIL b_rk10: got %h expected %h", dut.rk_q[10], RK10_2); end
    send_ct(CT2, ok);
    wait_pt(ok, edges);
    checks++; if (!ok || pt_out !== PT2) begin errors++; $display("[TB] FAIL b_plaintext: got %h expected %h", pt_out, PT2); end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int edges;
    send_ct(CT2, ok);
    wait_pt(ok, edges);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_first_result: got timeout expected pt_valid"); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ct_in = CT2; ct_valid = (i >= 10);
      #1;
      checks++;
      if (pt_valid !== 1'b1 || pt_out !== PT2 || ct_ready !== 1'b0 || key_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_hold cycle %0d: got v=%b out=%h ctr=%b kr=%b expected v=1 out=%h ctr=0 kr=0",
                 i, pt_valid, pt_out, ct_ready, key_ready, PT2);
      end
    end
    @(negedge clk);
    ct_in = CT2; ct_valid = 1'b1; pt_ready = 1'b1;
    #1;
    checks++; if (ct_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_same_cycle_ready: got %b expected 1", ct_ready); end
    @(posedge clk);
    #1 ct_valid = 1'b0; pt_ready = 1'b0;
    checks++; if (pt_valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_released: got %b expected 0", pt_valid); end
    wait_pt(ok, edges);
    checks++; if (!ok || edges != 10 || pt_out !== PT2) begin errors++; $display("[TB] FAIL bp_second_block: got %h after %0d edges expected %h after 10", pt_out, edges, PT2); end
    consume();
  endtask

  task automatic test_ct_blocked();
    bit ok;
    int edges;
    bit timed_out;
    reset_dut();
    ct_in = CT1; ct_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      checks++; if (ct_ready !== 1'b0 || pt_valid !== 1'b0) begin errors++; $display("[TB] FAIL nokey_ct_ready: got ctr=%b v=%b expected 0 0", ct_ready, pt_valid); end
    end
    @(negedge clk);
    key_in = K2; key_valid = 1'b1;
    #1;
    checks++; if (key_ready !== 1'b1) begin errors++; $display("[TB] FAIL nokey_key_ready: got %b expected 1", key_ready); end
    @(posedge clk);
    #1 key_valid = 1'b0;
    timed_out = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (keys_rdy === 1'b1) begin timed_out = 1'b0; break; end
      checks++;
      if (ct_ready !== 1'b0 || key_ready !== 1'b0 || pt_valid !== 1'b0) begin
        errors++; $display("[TB] FAIL expand_blocked: got ctr=%b kr=%b v=%b expected 0 0 0", ct_ready, key_ready, pt_valid);
      end
      @(posedge clk);
      #1;
    end
    ct_valid = 1'b0;
    checks++; if (timed_out) begin errors++; $display("[TB] FAIL expand_done: got timeout expected keys_rdy"); end
    @(negedge clk);
    key_in = K1; key_valid = 1'b1; ct_in = CT1; ct_valid = 1'b1;
    #1;
    checks++; if (key_ready !== 1'b1 || ct_ready !== 1'b0) begin errors++; $display("[TB] FAIL priority_ready: got kr=%b ctr=%b expected 1 0", key_ready, ct_ready); end
    @(posedge clk);
    #1 key_valid = 1'b0; ct_valid = 1'b0;
    checks++; if (keys_rdy !== 1'b0) begin errors++; $display("[TB] FAIL priority_keys_drop: got %b expected 0", keys_rdy); end
    wait_keys(ok, edges);
    send_ct(CT1, ok);
    wait_pt(ok, edges);
    checks++; if (!ok || pt_out !== PT1) begin errors++; $display("[TB] FAIL priority_result: got %h expected %h", pt_out, PT1); end
    consume();
  endtask

  task automatic test_reset_mid_dec();
    bit ok;
    int edges;
    send_ct(CT1, ok);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (pt_valid !== 1'b0 || keys_rdy !== 1'b0 || pt_out !== 128'h0) begin
      errors++; $display("[TB] FAIL abort_state: got v=%b kr=%b out=%h expected 0 0 0", pt_valid, keys_rdy, pt_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      checks++; if (pt_valid !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_output: got %b expected 0", pt_valid); end
    end
    send_key(K1, ok);
    wait_keys(ok, edges);
    send_ct(CT1, ok);
    wait_pt(ok, edges);
    checks++; if (!ok || edges != 10 || pt_out !== PT1) begin errors++; $display("[TB] FAIL abort_rerun: got %h after %0d edges expected %h after 10", pt_out, edges, PT1); end
    consume();
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2, ok3;
    int edges;
    logic [127:0] k, p, c;
    for (int n = 0; n < 50; n++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      p = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      c = model_encrypt(p);
      send_key(k, ok1);
      wait_keys(ok2, edges);
      send_ct(c, ok3);
      ok1 = ok1 & ok2 & ok3;
      wait_pt(ok2, edges);
      checks++;
      if (!ok1 || !ok2 || pt_out !== p) begin
        errors++; $display("[TB] FAIL roundtrip %0d: got %h expected %h", n, pt_out, p);
      end
      consume();
    end
  endtask

  initial begin
    rst_n = 1'b0; key_valid = 1'b0; ct_valid = 1'b0; pt_ready = 1'b0;
    key_in = '0; ct_in = '0;
    init_model();
    test_reset();
    test_fips_c1();
    test_fips_b();
    test_backpressure();
    test_ct_blocked();
    test_reset_mid_dec();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
